// File: rtl/datapath_pkg.sv
// Shared definitions for the 16-bit RISC execution datapath: ALU function
// codes, mux select values and address widths.
package datapath_pkg;

    localparam int REG_AW = 4;
    localparam int MEM_AW = 6;

    typedef enum logic [2:0] {
        FS_ADD = 3'b000,
        FS_SUB = 3'b001,
        FS_AND = 3'b010,
        FS_OR  = 3'b011,
        FS_XOR = 3'b100,
        FS_NOT = 3'b101,
        FS_SHL = 3'b110,
        FS_SHR = 3'b111
    } fs_e;

    localparam logic MB_REG   = 1'b0;
    localparam logic MB_CONST = 1'b1;
    localparam logic MD_ALU   = 1'b0;
    localparam logic MD_MEM   = 1'b1;
    localparam logic MM_ABUS  = 1'b0;
    localparam logic MM_PC    = 1'b1;

endpackage

// File: rtl/datapath_register_file.sv
// Register file: nReg x nBit, two asynchronous read ports, one synchronous
// write port, whole array cleared by synchronous reset. No write bypass.
module register_file
    import datapath_pkg::*;
#(
    parameter int nBit = 16,
    parameter int nReg = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [nBit-1:0]   wd,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    output logic [nBit-1:0]   qa,
    output logic [nBit-1:0]   qb
);

    logic [nBit-1:0] regs [nReg];

    // Register array update: full clear on reset, else single-port write.
    // NOTE: the array carries a reset because software relies on every
    // register reading zero after reset; this rules out mapping it onto a
    // RAM macro, which is acceptable at 16 entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < nReg; i++) begin
                // NOTE: state in always_ff is always assigned with <= so every
                // reader sees the pre-edge value regardless of block order.
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    // Asynchronous reads return the old value during a same-cycle write.
    assign qa = regs[ra];
    assign qb = regs[rb];

endmodule

// File: rtl/datapath.sv
// Execution datapath: register file, 8-function ALU, 64-word data RAM and
// the registered zero flag. Driven by the controller's decoded control word.
module datapath
    import datapath_pkg::*;
#(
    parameter int nBit = 16,
    parameter int nReg = 16,
    parameter int nMem = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] DA,
    input  logic [REG_AW-1:0] AA,
    input  logic [REG_AW-1:0] BA,
    input  logic [2:0]        FS,
    input  logic              RW,
    input  logic              MB,
    input  logic              MK,
    input  logic              MD,
    input  logic              MM,
    input  logic              MW,
    input  logic              A_thru,
    input  logic              B_thru,
    input  logic [MEM_AW-1:0] PC,
    input  logic              done,
    output logic [nBit-1:0]   A_bus,
    output logic [nBit-1:0]   B_bus,
    output logic [nBit-1:0]   F,
    output logic              zero_flag
);

    logic [nBit-1:0]   rf_b;
    logic [nBit-1:0]   konst;
    logic [nBit-1:0]   alu_out;
    logic [nBit-1:0]   ram_rd;
    logic [nBit-1:0]   wb_data;
    logic [MEM_AW-1:0] ram_addr;
    logic [nBit-1:0]   mem [nMem];

    register_file #(
        .nBit (nBit),
        .nReg (nReg)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (RW && !done),
        .wa    (DA),
        .wd    (wb_data),
        .ra    (AA),
        .rb    (BA),
        .qa    (A_bus),
        .qb    (rf_b)
    );

    // Immediate operand: 4-bit zero-extended BA, or sign-extended {AA,BA}.
    assign konst = MK ? {{(nBit-8){AA[3]}}, AA, BA}
                      : {{(nBit-REG_AW){1'b0}}, BA};

    assign B_bus = (MB == MB_CONST) ? konst : rf_b;

    // ALU function decode; all arithmetic wraps at nBit, carry discarded.
    always_comb begin
        // NOTE: default first so every path assigns alu_out and no latch forms.
        alu_out = '0;
        case (fs_e'(FS))
            FS_ADD:  alu_out = A_bus + B_bus;
            FS_SUB:  alu_out = A_bus - B_bus;
            FS_AND:  alu_out = A_bus & B_bus;
            FS_OR:   alu_out = A_bus | B_bus;
            FS_XOR:  alu_out = A_bus ^ B_bus;
            FS_NOT:  alu_out = ~A_bus;
            FS_SHL:  alu_out = {A_bus[nBit-2:0], 1'b0};
            FS_SHR:  alu_out = {1'b0, A_bus[nBit-1:1]};
            default: alu_out = '0;
        endcase
    end

    // Pass-through overrides; A_thru wins when both are set.
    assign F = A_thru ? A_bus : (B_thru ? B_bus : alu_out);

    // RAM address wraps modulo nMem because only the low bits of A_bus are used.
    assign ram_addr = (MM == MM_PC) ? PC : A_bus[MEM_AW-1:0];
    assign ram_rd   = mem[ram_addr];
    assign wb_data  = (MD == MD_MEM) ? ram_rd : F;

    // Data RAM: cleared on reset, written with the pre-edge B_bus when MW.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < nMem; i++) begin
                mem[i] <= '0;
            end
        end else if (MW && !done) begin
            mem[ram_addr] <= B_bus;
        end
    end

    // Zero flag tracks ALU write-backs only; RAM loads leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_flag <= 1'b0;
        end else if (RW && (MD == MD_ALU) && !done) begin
            zero_flag <= (F == '0);
        end
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Execution datapath that sits directly downstream of the controller in the 16-bit RISC processor.
- Consumes the controller's decoded control word: DA/AA/BA, FS, RW, MB, MD, MK, MM, MW, A_thru, B_thru, PC and done.
- Contains a 16x16 register file, an 8-function ALU, a 64x16 data RAM and the registered zero flag.
- Returns A_bus and zero_flag to the controller.

Parameters:
- nBit, 16, datapath word width.
- nReg, 16, number of registers; address width is 4.
- nMem, 64, data RAM depth; address width is 6.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- DA  in  4  destination register address.
- AA  in  4  A-operand register address.
- BA  in  4  B-operand register address.
- FS  in  3  ALU function select.
- RW  in  1  register write enable.
- MB  in  1  B-operand mux: 0 = register[BA], 1 = constant.
- MK  in  1  constant select: 0 = {12'b0,BA}; 1 = sign-extend {AA,BA} (8-bit).
- MD  in  1  write-back mux: 0 = ALU result, 1 = RAM read data.
- MM  in  1  RAM address mux: 0 = A_bus[5:0], 1 = PC.
- MW  in  1  RAM write enable.
- A_thru  in  1  force F = A operand.
- B_thru  in  1  force F = B operand; A_thru has priority.
- PC  in  6  current program counter.
- done  in  1  processor halted; freezes all state.
- A_bus  out  nBit  register[AA], combinational; feeds the controller's A input.
- B_bus  out  nBit  selected B operand, combinational.
- F  out  nBit  ALU result, combinational.
- zero_flag  out  1  registered zero flag.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset state: all 16 registers, all 64 RAM words and zero_flag are cleared to 0 on the clk edge where reset=1. Reset overrides RW, MW and done.
- Register file reads: asynchronous. A read of the register being written in the same cycle returns the old value; the new value is visible the next cycle. There is no bypass.
- ALU FS encoding (all arithmetic mod 2^16, carry discarded):
  - 000 ADD A+B
  - 001 SUB A-B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A
  - 110 SHL A by 1, zero fill
  - 111 SHR A by 1, logical
- ALU overrides: A_thru=1 gives F=A. B_thru=1 with A_thru=0 gives F=B. Both set gives F=A.
- Write-back: at posedge, if RW=1 and done=0, register[DA] is loaded with (MD ? ram_rd : F). Register R0 is writable; there is no hardwired zero.
- Data RAM:
  - Address = MM ? PC : A_bus[5:0]. Upper A_bus bits are ignored, so addresses wrap modulo 64.
  - Read is asynchronous.
  - Write at posedge when MW=1 and done=0; write data = B_bus.
- Zero flag: updated at posedge with (F==0) when RW=1, MD=0 and done=0. Otherwise it holds. A load from RAM does not affect the flag.
- Simultaneous RW and MW: both writes take effect in the same edge. RAM write data uses the pre-edge B_bus.
- Simultaneous read and write at the same RAM address: the read returns the old data during that cycle.
- Halt: while done=1, no register, RAM or flag changes; combinational outputs remain live.
- Reset mid-instruction: any pending write in that cycle is discarded.
- Latency: combinational from control inputs to F, A_bus and B_bus; 1 cycle to state update.

Decomposition:
- Shared package contains:
  - FS encodings: FS_ADD … FS_SHR.
  - Mux select constants: MB_REG/MB_CONST, MD_ALU/MD_MEM, MM_ABUS/MM_PC.
  - Widths: REG_AW=4, MEM_AW=6.
- One natural sub-module: register_file, holding the 16xnBit array, two async read ports and one sync write port with reset clear.
- ALU and RAM stay inline.

Test Plan:
1. Reset, then RW=1, MB=1, MK=0, BA=5, AA=0, FS=ADD, DA=1 -> R1=5, zero_flag=0. Next cycle, AA=1 gives A_bus=0x0005.
2. R1=5, R2=5. FS=SUB, AA=1, BA=2, MB=0, DA=3, RW=1 -> R3=0, zero_flag=1. A following cycle with RW=0 keeps zero_flag=1.
3. MK=1, AA=4'hF, BA=4'hE, MB=1, B_thru=1, DA=4, RW=1 -> R4=0xFFFE. Then FS=SHR on R4 -> 0x7FFF.
4. Store/load:
   - R1=0x0043, R2=0x1234. MW=1, MM=0, AA=1, BA=2, MB=0 -> RAM[3]=0x1234 (address wraps 0x43 mod 64).
   - Next cycle MD=1, RW=1, DA=6, AA=1 -> R6=0x1234, zero_flag unchanged.
5. done=1 with RW=1, MW=1, DA=7, any F -> R7, RAM and zero_flag unchanged. Deasserting done resumes writes.
6. Reset asserted in the same cycle as RW=1 writing R1=0xAAAA -> R1=0, zero_flag=0.
